// File: rtl/pc_control_pkg.sv
// Shared constants and state encoding for the fetch-stage PC sequencer.
package pc_control_pkg;

  localparam int PC_WIDTH = 16;
  localparam int PC_INC   = 2;

  typedef enum logic [1:0] {
    PCC_RUN     = 2'b00,
    PCC_DROP    = 2'b01,
    PCC_HALT    = 2'b10,
    PCC_ILLEGAL = 2'b11
  } pcc_state_t;

endpackage

// File: rtl/pc_control_adder.sv
// Sequential next-PC adder: pc_cur plus a constant increment, carry discarded.
module pc_control_adder #(
  parameter int WIDTH = 16,
  parameter int INC   = 2
) (
  input  logic [WIDTH-1:0] pc_cur,
  output logic [WIDTH-1:0] pc_inc
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  assign pc_inc = pc_cur + INC_W;

endmodule

// File: rtl/pc_control.sv
// Fetch-stage PC sequencer: next-PC selection, fetch handshake, wrong-path drop
// and a saturating count of cycles in which the PC did not advance.
module pc_control
  import pc_control_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int INC   = PC_INC,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_cur,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_wen,
  output logic             fetch_req,
  input  logic             fetch_ack,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             halt,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  pcc_state_t       state;
  pcc_state_t       state_nxt;
  logic [WIDTH-1:0] pc_inc;
  logic             cnt_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  pc_control_adder #(
    .WIDTH (WIDTH),
    .INC   (INC)
  ) u_adder (
    .pc_cur (pc_cur),
    .pc_inc (pc_inc)
  );

  always_comb begin
    pc_next   = pc_inc;
    pc_wen    = 1'b0;
    fetch_req = 1'b0;
    flush     = 1'b0;
    halted    = 1'b0;
    state_nxt = state;
    if (rst) begin
      pc_next   = '0;
      state_nxt = PCC_RUN;
    end else begin
      unique case (state)
        PCC_RUN: begin
          fetch_req = 1'b1;
          if (branch_taken) begin
            pc_wen  = 1'b1;
            pc_next = branch_target;
            flush   = 1'b1;
            if (!fetch_ack) state_nxt = PCC_DROP;
          end else if (halt) begin
            state_nxt = PCC_HALT;
          end else if (fetch_ack && !stall) begin
            pc_wen = 1'b1;
          end
        end
        PCC_DROP: begin
          // A branch coinciding with the stale ack still redirects; returning to
          // RUN then avoids waiting for an ack that was never requested.
          if (fetch_ack) begin
            flush     = 1'b1;
            state_nxt = PCC_RUN;
          end
          if (branch_taken) begin
            pc_wen  = 1'b1;
            pc_next = branch_target;
          end
        end
        PCC_HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_nxt = PCC_RUN;
        end
      endcase
    end
  end

  assign cnt_en = !rst && !pc_wen && ((state == PCC_RUN) || (state == PCC_DROP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PCC_RUN;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_en) stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control with a small PC register around it.
module tb_pc_control;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pc_cur;
  logic [WIDTH-1:0] pc_next;
  logic             pc_wen;
  logic             fetch_req;
  logic             fetch_ack;
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             halt;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  logic             tb_load;
  logic [WIDTH-1:0] tb_load_val;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_control #(
    .WIDTH (WIDTH),
    .INC   (2),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_cur        (pc_cur),
    .pc_next       (pc_next),
    .pc_wen        (pc_wen),
    .fetch_req     (fetch_req),
    .fetch_ack     (fetch_ack),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .flush         (flush),
    .halted        (halted),
    .stall_count   (stall_count)
  );

  // PC register sharing rst with the sequencer; tb_load presets arbitrary PCs.
  always @(posedge clk) begin
    if (rst) pc_cur <= '0;
    else if (tb_load) pc_cur <= tb_load_val;
    else if (pc_wen) pc_cur <= pc_next;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; fetch_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = '0; halt = 1'b0; tb_load = 1'b0; tb_load_val = '0;

    // T1: reset, then sequential fetch
    tick();
    settle();
    chk("rst_pc_wen", 32'(pc_wen), 0);
    chk("rst_fetch_req", 32'(fetch_req), 0);
    chk("rst_pc_next", 32'(pc_next), 0);
    chk("rst_flush", 32'(flush), 0);
    tick();
    chk("rst_count", 32'(stall_count), 0);
    chk("rst_halted", 32'(halted), 0);
    rst = 1'b0; fetch_ack = 1'b1;
    settle();
    chk("t1_pc0", 32'(pc_cur), 'h0000);
    chk("t1_wen0", 32'(pc_wen), 1);
    chk("t1_req0", 32'(fetch_req), 1);
    chk("t1_next0", 32'(pc_next), 'h0002);
    tick();
    chk("t1_pc1", 32'(pc_cur), 'h0002);
    settle();
    chk("t1_wen1", 32'(pc_wen), 1);
    tick();
    chk("t1_pc2", 32'(pc_cur), 'h0004);
    chk("t1_count", 32'(stall_count), 0);

    // T3: stall with ack holds PC
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_wen", 32'(pc_wen), 0);
      tick();
    end
    chk("t3_count", 32'(stall_count), 3);
    chk("t3_pc_held", 32'(pc_cur), 'h0004);
    stall = 1'b0;

    // T2: wrap at the top of the address space
    tb_load = 1'b1; tb_load_val = 16'hFFFE;
    tick();
    tb_load = 1'b0;
    settle();
    chk("t2_wrap_next", 32'(pc_next), 'h0000);
    chk("t2_wrap_wen", 32'(pc_wen), 1);
    tick();
    chk("t2_wrap_pc", 32'(pc_cur), 'h0000);

    // T4: branch with fetch in flight, then a redirect while dropping
    fetch_ack = 1'b0; branch_taken = 1'b1; branch_target = 16'h0040;
    settle();
    chk("t4_next", 32'(pc_next), 'h0040);
    chk("t4_wen", 32'(pc_wen), 1);
    chk("t4_flush", 32'(flush), 1);
    tick();
    branch_target = 16'h0080; halt = 1'b1;
    settle();
    chk("t4_drop_req", 32'(fetch_req), 0);
    chk("t4_drop_br_next", 32'(pc_next), 'h0080);
    chk("t4_drop_br_wen", 32'(pc_wen), 1);
    chk("t4_drop_br_flush", 32'(flush), 0);
    tick();
    branch_taken = 1'b0; halt = 1'b0;
    settle();
    chk("t4_drop_wait_wen", 32'(pc_wen), 0);
    chk("t4_drop_wait_halted", 32'(halted), 0);
    tick();
    chk("t4_count_a", 32'(stall_count), 4);
    fetch_ack = 1'b1;
    settle();
    chk("t4_stale_flush", 32'(flush), 1);
    chk("t4_stale_wen", 32'(pc_wen), 0);
    tick();
    chk("t4_count_b", 32'(stall_count), 5);
    settle();
    chk("t4_run_req", 32'(fetch_req), 1);
    chk("t4_run_next", 32'(pc_next), 'h0082);
    chk("t4_run_wen", 32'(pc_wen), 1);
    tick();

    // T5: branch beats halt, then halt alone stops the core
    branch_taken = 1'b1; halt = 1'b1; branch_target = 16'h0100;
    settle();
    chk("t5_br_next", 32'(pc_next), 'h0100);
    chk("t5_br_wen", 32'(pc_wen), 1);
    tick();
    branch_taken = 1'b0;
    settle();
    chk("t5_br_halted", 32'(halted), 0);
    chk("t5_halt_wen", 32'(pc_wen), 0);
    chk("t5_halt_flush", 32'(flush), 0);
    tick();
    halt = 1'b0; branch_taken = 1'b1; branch_target = 16'h0200;
    settle();
    chk("t5_halted", 32'(halted), 1);
    chk("t5_halt_req", 32'(fetch_req), 0);
    chk("t5_halt_br_wen", 32'(pc_wen), 0);
    chk("t5_halt_br_flush", 32'(flush), 0);
    tick();
    chk("t5_count", 32'(stall_count), 6);
    chk("t5_pc", 32'(pc_cur), 'h0100);
    branch_taken = 1'b0;
    rst = 1'b1;
    settle();
    chk("t5_rst_halted", 32'(halted), 0);
    tick();
    rst = 1'b0;
    settle();
    chk("t5_after_rst_req", 32'(fetch_req), 1);
    chk("t5_after_rst_count", 32'(stall_count), 0);

    // T6: reset while dropping, then counter saturation
    fetch_ack = 1'b0; branch_taken = 1'b1; branch_target = 16'h0040;
    tick();
    branch_taken = 1'b0;
    settle();
    chk("t6_in_drop", 32'(fetch_req), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("t6_req", 32'(fetch_req), 1);
    chk("t6_flush", 32'(flush), 0);
    chk("t6_count", 32'(stall_count), 0);
    for (int i = 0; i < 15; i++) tick();
    chk("t6_count_full", 32'(stall_count), 15);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_count_sat", 32'(stall_count), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
